// File: rtl/seq_pkg.sv
// Shared types and constants for the program sequencer: state encoding,
// PC width and the per-program base addresses.
package seq_pkg;

  localparam int PC_W      = 10;
  localparam int NUM_PROGS = 3;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DONE
  } state_e;

  localparam logic [PC_W-1:0] PROG_BASE [NUM_PROGS] = '{10'd0, 10'd200, 10'd450};

endpackage

// File: rtl/cycle_counter.sv
// Saturating up-counter with synchronous clear and count enable; clear wins.
module cycle_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/prog_sequencer.sv
// Run controller in front of the fetch PC: loads each program base, gates
// control-unit branches during RUN, detects halt and counts RUN cycles.
// Build option WATCHDOG_EN ends a RUN after MAX_CYCLES cycles with Timeout set.
//
// state | meaning
// IDLE  | after reset, PC held, waiting for first Start
// LOAD  | PC forced to PROG_BASE[ProgIdx] while Start is high
// RUN   | program executing, branches passed through to fetch
// DONE  | program halted (or timed out), PC held, results stable
module prog_sequencer #(
  parameter int PC_W       = seq_pkg::PC_W,
  parameter int NUM_PROGS  = seq_pkg::NUM_PROGS,
  parameter int CNT_W      = 16,
  parameter int MAX_CYCLES = 4096,
  localparam int IDX_W     = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Halt,
  input  logic             BrTaken,
  input  logic             BrAbsOrRel,
  input  logic [PC_W-1:0]  BrTarget,
  output logic             FetchHold,
  output logic             FetchJump,
  output logic             FetchAbsOrRel,
  output logic [PC_W-1:0]  FetchTarget,
  output logic [IDX_W-1:0] ProgIdx,
  output logic             Busy,
  output logic             Done,
  output logic [CNT_W-1:0] CycleCount,
  output logic             Timeout
);

  import seq_pkg::*;

`ifdef WATCHDOG_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  state_e           state_q, state_d;
  logic [IDX_W-1:0] prog_idx_q, prog_idx_d;
  logic             timeout_q, timeout_d;
  logic             cnt_clr, cnt_en, wd_hit;

  // CycleCount still holds the previous cycle's total, so MAX_CYCLES-1 marks the last allowed cycle.
  assign wd_hit = WD_EN && (CycleCount == CNT_W'(MAX_CYCLES - 1)) && !Halt;

  always_comb begin
    state_d       = state_q;
    prog_idx_d    = prog_idx_q;
    timeout_d     = timeout_q;
    cnt_clr       = 1'b0;
    cnt_en        = 1'b0;
    FetchHold     = 1'b1;
    FetchJump     = 1'b0;
    FetchAbsOrRel = 1'b0;
    FetchTarget   = '0;
    Busy          = 1'b0;
    Done          = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (Start) begin
          state_d    = LOAD;
          prog_idx_d = '0;
        end
      end
      LOAD: begin
        FetchHold   = 1'b0;
        FetchJump   = 1'b1;
        FetchTarget = PC_W'(PROG_BASE[prog_idx_q]);
        Busy        = 1'b1;
        cnt_clr     = 1'b1;
        timeout_d   = 1'b0;
        if (!Start) state_d = RUN;
      end
      RUN: begin
        Busy   = 1'b1;
        cnt_en = 1'b1;
        if (Halt) begin
          state_d = DONE;
        end else if (wd_hit) begin
          state_d   = DONE;
          timeout_d = 1'b1;
        end else begin
          FetchHold     = 1'b0;
          FetchJump     = BrTaken;
          FetchAbsOrRel = BrAbsOrRel;
          FetchTarget   = BrTaken ? BrTarget : '0;
        end
      end
      DONE: begin
        Done = 1'b1;
        if (Start) begin
          state_d    = LOAD;
          prog_idx_d = (prog_idx_q == IDX_W'(NUM_PROGS - 1)) ? '0 : prog_idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= IDLE;
      prog_idx_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      prog_idx_q <= prog_idx_d;
      timeout_q  <= timeout_d;
    end
  end

  cycle_counter #(.W(CNT_W)) u_cycle_counter (
    .clk   (Clk),
    .rst   (Reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .count (CycleCount)
  );

  assign ProgIdx = prog_idx_q;
  assign Timeout = timeout_q;

endmodule

// File: tb/tb_prog_sequencer.sv
// Scoreboard bench for prog_sequencer: a phase-level reference model plus a
// PC model drive directed and random programs; a monitor checks every cycle.
module tb_prog_sequencer;

  localparam int MAXC = 16;
`ifdef WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif
  localparam int BASES [3] = '{0, 200, 450};

  logic       Clk, Reset, Start, Halt, BrTaken, BrAbsOrRel;
  logic [9:0] BrTarget, FetchTarget;
  logic       FetchHold, FetchJump, FetchAbsOrRel, Busy, Done, Timeout;
  logic [1:0] ProgIdx;
  logic [15:0] CycleCount;

  prog_sequencer #(.PC_W(10), .NUM_PROGS(3), .CNT_W(16), .MAX_CYCLES(MAXC)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Halt(Halt), .BrTaken(BrTaken),
    .BrAbsOrRel(BrAbsOrRel), .BrTarget(BrTarget), .FetchHold(FetchHold),
    .FetchJump(FetchJump), .FetchAbsOrRel(FetchAbsOrRel), .FetchTarget(FetchTarget),
    .ProgIdx(ProgIdx), .Busy(Busy), .Done(Done), .CycleCount(CycleCount), .Timeout(Timeout)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct packed {
    logic       hold;
    logic       jump;
    logic       abs_rel;
    logic [9:0] tgt;
    logic [1:0] idx;
    logic       busy;
    logic       done;
    logic [15:0] cnt;
    logic       to;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;

  // phase: 0 idle, 1 loading, 2 running, 3 finished
  int ph, m_idx, m_cnt, m_pc;
  bit m_to;

  task automatic step(input bit rst, input bit st, input bit h, input bit b,
                      input bit r, input logic [9:0] t);
    exp_t e;
    bit wd_hit;
    @(posedge Clk);
    #1;
    Reset = rst; Start = st; Halt = h; BrTaken = b; BrAbsOrRel = r; BrTarget = t;
    e = '0;
    e.idx = 2'(m_idx);
    e.cnt = 16'(m_cnt);
    e.to  = m_to;
    wd_hit = WD && (m_cnt == MAXC - 1) && !h;
    case (ph)
      0: e.hold = 1'b1;
      1: begin e.jump = 1'b1; e.tgt = 10'(BASES[m_idx]); e.busy = 1'b1; end
      2: begin
        e.busy = 1'b1;
        if (h || wd_hit) e.hold = 1'b1;
        else begin e.jump = b; e.abs_rel = r; e.tgt = b ? t : 10'd0; end
      end
      default: begin e.hold = 1'b1; e.done = 1'b1; end
    endcase
    exp_q.push_back(e);
    if (!e.hold) begin
      if (e.jump) m_pc = e.abs_rel ? (m_pc + int'(e.tgt)) % 1024 : int'(e.tgt);
      else m_pc = (m_pc + 1) % 1024;
    end
    if (rst) begin
      ph = 0; m_idx = 0; m_cnt = 0; m_to = 1'b0;
    end else begin
      case (ph)
        0: if (st) begin ph = 1; m_idx = 0; end
        1: begin m_cnt = 0; m_to = 1'b0; if (!st) ph = 2; end
        2: begin
          m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
          if (h) ph = 3;
          else if (wd_hit) begin ph = 3; m_to = 1'b1; end
        end
        default: if (st) begin ph = 1; m_idx = (m_idx + 1) % 3; end
      endcase
    end
  endtask

  task automatic load(input int n);
    for (int i = 0; i < n; i++) step(0, 1, 0, 0, 0, 10'd0);
    step(0, 0, 0, 0, 0, 10'd0);
  endtask

  // Run until halt at a given PC offset from the current program base.
  task automatic run_to_halt(input int off);
    for (int k = 0; k < 100 && ph == 2; k++)
      step(0, 0, (m_pc == BASES[m_idx] + off), 0, 0, 10'd0);
  endtask

  initial begin
    forever begin
      @(negedge Clk);
      cyc++;
      if (exp_q.size() > 0) begin
        exp_t e, a;
        e = exp_q.pop_front();
        a = {FetchHold, FetchJump, FetchAbsOrRel, FetchTarget, ProgIdx, Busy, Done, CycleCount, Timeout};
        total++;
        if (a !== e) begin
          bad++;
          $display("FAIL cycle%0d outputs: got hold=%0b jump=%0b rel=%0b tgt=%0d idx=%0d busy=%0b done=%0b cnt=%0d to=%0b, need hold=%0b jump=%0b rel=%0b tgt=%0d idx=%0d busy=%0b done=%0b cnt=%0d to=%0b",
                   cyc, a.hold, a.jump, a.abs_rel, a.tgt, a.idx, a.busy, a.done, a.cnt, a.to,
                   e.hold, e.jump, e.abs_rel, e.tgt, e.idx, e.busy, e.done, e.cnt, e.to);
        end
      end
    end
  end

  initial begin
    Reset = 1'b1; Start = 1'b0; Halt = 1'b0; BrTaken = 1'b0; BrAbsOrRel = 1'b0; BrTarget = '0;
    repeat (2) @(posedge Clk);
    ph = 0; m_idx = 0; m_cnt = 0; m_to = 1'b0; m_pc = 0;

    // reset state, then program 0 halting at PC 6 after 7 cycles
    step(1, 0, 0, 0, 0, 10'd0);
    step(1, 0, 0, 0, 0, 10'd0);
    load(3);
    run_to_halt(6);
    step(0, 0, 0, 0, 0, 10'd0);

    // program 1: relative branch -2 at base+5, halt at base+8
    load(1);
    for (int k = 0; k < 100 && ph == 2; k++) begin
      if (m_pc == BASES[m_idx] + 5 && m_cnt < 6) step(0, 0, 0, 1, 1, 10'h3FE);
      else step(0, 0, (m_pc == BASES[m_idx] + 8), 0, 0, 10'd0);
    end

    // program 2: branch and halt in the same cycle, halt wins
    load(1);
    for (int k = 0; k < 100 && ph == 2; k++)
      step(0, 0, (m_pc == BASES[m_idx] + 5), (m_pc == BASES[m_idx] + 5), 1, 10'h3FE);
    step(0, 0, 0, 0, 0, 10'd0);

    // wrap to program 0, reset mid-run at CycleCount 5
    load(2);
    for (int k = 0; k < 100 && !(ph == 2 && m_cnt == 5); k++) step(0, 0, 0, 0, 0, 10'd0);
    step(1, 0, 0, 0, 0, 10'd0);
    step(0, 0, 0, 0, 0, 10'd0);

    // long run without halt (watchdog expiry when enabled), then halt on cycle 16
    load(1);
    for (int k = 0; k < 20 && ph == 2; k++) step(0, 0, 0, 0, 0, 10'd0);
    for (int k = 0; k < 30 && ph == 2; k++) step(0, 0, 1, 0, 0, 10'd0);
    step(0, 0, 0, 0, 0, 10'd0);
    load(1);
    for (int k = 0; k < 30 && ph == 2; k++) step(0, 0, (m_cnt == MAXC - 1), 0, 0, 10'd0);
    step(0, 0, 0, 0, 0, 10'd0);

    // random programs with random branches, Start noise and occasional resets
    for (int p = 0; p < 20; p++) begin
      load($urandom_range(1, 3));
      for (int k = 0; k < 60 && ph == 2; k++) begin
        bit rst, h, b;
        rst = ($urandom_range(0, 59) == 0);
        h   = ($urandom_range(0, 5) == 0) || (k > 40);
        b   = ($urandom_range(0, 3) == 0);
        step(rst, $urandom_range(0, 1), h, b, $urandom_range(0, 1), 10'($urandom));
      end
      repeat ($urandom_range(0, 2)) step(0, 0, $urandom_range(0, 1), $urandom_range(0, 1), 0, 10'($urandom));
    end

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge Clk);
    if (exp_q.size() > 0) begin
      bad++;
      $display("FAIL drain: got %0d pending, need 0", exp_q.size());
    end
    @(negedge Clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
